load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit for the simple RISC-V example core. It takes the base register value, the sign-extended offset and the store data read from the register set. It runs one word-aligned memory bus transaction with a req/ack handshake, then aligns and extends load data. It drives the register-set write port (data, destination address, write enable) directly, so it sits immediately upstream of the register set's write side.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles bus_req stays high without bus_ack before the access is aborted with a fault (range 1..255, held in an 8-bit counter).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RES  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request; accepted only when busy=0.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; sampled with start.
- base  in  32  rs1 value.
- offset  in  32  sign-extended immediate.
- store_data  in  32  rs2 value.
- rd  in  5  load destination register.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- fault  out  1  high together with done on a misaligned access, illegal funct3 or timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address (effective address with bits [1:0] = 00).
- bus_wdata  out  32  lane-replicated store data.
- bus_wmask  out  4  byte enables, bit n = byte lane n.
- bus_ack  in  1  transaction complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read word.
- rf_D  out  32  register write data.
- rf_A_D  out  5  register write address.
- rf_write_enable  out  1  register write strobe.

## Operation
- Effective address: ea = base + offset, mod 2^32; wrap-around is ignored.
- States: IDLE, REQ, FIN.
- IDLE with start=1: all inputs are captured.
  - Misaligned access (H/HU with ea[0]=1, W with ea[1:0]≠0) or illegal funct3 (011, 110, 111; BU/HU with is_store=1): go to FIN with the fault flag set. No bus transaction occurs.
  - Otherwise: go to REQ.
- REQ: bus_req=1; bus_addr, bus_we, bus_wdata and bus_wmask are held stable.
  - bus_ack=1: capture bus_rdata and go to FIN.
  - Otherwise the timeout counter increments. When TIMEOUT_CYCLES consecutive cycles pass without ack, go to FIN with the fault flag set.
- FIN: done=1 and fault=flag. For a non-faulting load with rd≠0: rf_write_enable=1, rf_A_D=rd, rf_D=extracted value. Then go to IDLE.
- Store lanes:
  - B: wdata = {4{sd[7:0]}}, wmask = 0001 << ea[1:0].
  - H: wdata = {2{sd[15:0]}}, wmask = 0011 << ea[1:0].
  - W: wdata = sd, wmask = 1111.
- Load extraction: select the byte or halfword at ea[1:0] from the captured word. B and H are sign-extended; BU and HU are zero-extended; W passes through.
- start while busy=1 is ignored and not queued.
- rf_write_enable is never asserted for rd=0, for a fault, or for a store.
- When bus_req=0, bus_we and bus_wmask are 0.

## Timing
- Reset: RES=1 at an edge forces IDLE on that edge. All outputs read 0 afterwards, including rf_*, bus_*, done, fault and busy.
- Reset mid-REQ: bus_req drops the cycle after the reset edge, no register write occurs, and no done pulse is produced.
- Let start be sampled at edge 0.
  - bus_req rises after edge 0.
  - With ack sampled at edge k, done and rf_write_enable are high for exactly the cycle after edge k.
  - Minimum latency from start to done is therefore 2 cycles.
- Alignment fault: done and fault are high in the cycle after edge 0. bus_req never rises.
- Timeout: bus_req stays high for exactly TIMEOUT_CYCLES cycles. done and fault follow in the next cycle.
- A new start is accepted in the cycle done is high only if busy=0 in that cycle. busy drops together with done, so back-to-back operations have a 1-cycle gap.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- LB: base=0x1000, offset=3, rdata=0x80000000, ack on first REQ cycle -> bus_addr=0x1000, bus_wmask=0000, rf_D=0xFFFFFF80, rf_A_D=rd=5, done 2 cycles after start; the same case as LBU -> rf_D=0x00000080.
- SH: ea=0x1002, store_data=0x1234ABCD -> bus_we=1, bus_wdata=0xABCDABCD, bus_wmask=1100, no rf write, done with fault=0.
- LW at ea=0x1002, and SBU (funct3=100, is_store=1) -> bus_req stays 0, done=fault=1 one cycle after start, rf_write_enable=0.
- TIMEOUT_CYCLES=4, ack never asserted -> bus_req high for exactly 4 cycles, then done=fault=1, no write; a later ack is ignored.
- LW with rd=0, ack after 3 wait cycles -> done=1, rf_write_enable=0; a start pulsed during REQ is ignored, with no second transaction.
- RES asserted during REQ -> bus_req=0 and all outputs 0 after the reset edge; a fresh LW afterwards completes normally with rf_D=bus_rdata.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit for the simple RISC-V example core. One access
// runs as a single word-aligned bus transaction with a req/ack handshake. Load
// data is aligned and extended, then written straight into the register set.
//
// Ports:
//   CLK, RES          clock, synchronous active-high reset
//   start             single-cycle request, accepted only while busy=0
//   is_store, funct3  access kind and size, sampled with start
//   base, offset      effective address operands (ea = base + offset)
//   store_data, rd    store value and load destination register
//   busy, done, fault status; done is a one-cycle pulse, fault rides with it
//   bus_*             word-aligned memory bus (req/ack handshake)
//   rf_D, rf_A_D,
//   rf_write_enable   register set write port
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rf_D,
    output logic [4:0]  rf_A_D,
    output logic        rf_write_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter value in the last REQ cycle allowed before the access is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Illegal encodings, unsigned stores and misaligned halfword/word accesses.
    function automatic logic access_illegal(input logic       st,
                                            input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            3'b100:  bad = st;
            3'b101:  bad = st | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replicates store data across the lanes; returns {wdata, wmask}.
    function automatic logic [35:0] store_lanes(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] sd);
        logic [31:0] wdata;
        logic [3:0]  wmask;
        case (f3[1:0])
            2'b00: begin
                wdata = {4{sd[7:0]}};
                wmask = 4'b0001 << lo;
            end
            2'b01: begin
                wdata = {2{sd[15:0]}};
                wmask = 4'b0011 << lo;
            end
            default: begin
                wdata = sd;
                wmask = 4'b1111;
            end
        endcase
        return {wdata, wmask};
    endfunction

    // Picks the addressed byte/halfword out of the read word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  ea_lo_q, ea_lo_d;
    logic [4:0]  rd_q, rd_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wmask_q, bus_wmask_d;
    logic [31:0] rf_d_q, rf_d_d;
    logic [4:0]  rf_a_d_q, rf_a_d_d;
    logic        rf_we_q, rf_we_d;

    logic [31:0] ea;
    logic [35:0] lanes;

    always_comb begin
        ea          = base + offset;
        lanes       = '0;

        state_d     = state_q;
        tmo_d       = tmo_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        ea_lo_d     = ea_lo_q;
        rd_d        = rd_q;

        // Outputs default to the quiet value; each state re-asserts what it needs.
        busy_d      = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_wmask_d = '0;
        rf_d_d      = '0;
        rf_a_d_d    = '0;
        rf_we_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    ea_lo_d    = ea[1:0];
                    rd_d       = rd;
                    tmo_d      = '0;
                    busy_d     = 1'b1;
                    if (access_illegal(is_store, funct3, ea[1:0])) begin
                        // Rejected up front: straight to completion, no bus cycle.
                        state_d = FIN;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        bus_req_d  = 1'b1;
                        bus_we_d   = is_store;
                        bus_addr_d = {ea[31:2], 2'b00};
                        if (is_store) begin
                            lanes       = store_lanes(funct3, ea[1:0], store_data);
                            bus_wdata_d = lanes[35:4];
                            bus_wmask_d = lanes[3:0];
                        end
                    end
                end
            end

            REQ: begin
                busy_d = 1'b1;
                if (bus_ack) begin
                    // An ack in the last allowed cycle still completes normally.
                    state_d = FIN;
                    done_d  = 1'b1;
                    if (!is_store_q && (rd_q != 5'd0)) begin
                        rf_we_d  = 1'b1;
                        rf_a_d_d = rd_q;
                        rf_d_d   = load_extract(funct3_q, ea_lo_q, bus_rdata);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    tmo_d       = tmo_q + 8'd1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = bus_we_q;
                    bus_addr_d  = bus_addr_q;
                    bus_wdata_d = bus_wdata_q;
                    bus_wmask_d = bus_wmask_q;
                end
            end

            FIN: begin
                // done was raised on entry; starts seen here are dropped.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            rf_d_q      <= '0;
            rf_a_d_q    <= '0;
            rf_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            rf_d_q      <= rf_d_d;
            rf_a_d_q    <= rf_a_d_d;
            rf_we_q     <= rf_we_d;
        end
    end

    // Captured request attributes; only read while an access is in flight.
    always_ff @(posedge CLK) begin
        is_store_q <= is_store_d;
        funct3_q   <= funct3_d;
        ea_lo_q    <= ea_lo_d;
        rd_q       <= rd_d;
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign fault           = fault_q;
    assign bus_req         = bus_req_q;
    assign bus_we          = bus_we_q;
    assign bus_addr        = bus_addr_q;
    assign bus_wdata       = bus_wdata_q;
    assign bus_wmask       = bus_wmask_q;
    assign rf_D            = rf_d_q;
    assign rf_A_D          = rf_a_d_q;
    assign rf_write_enable = rf_we_q;

endmodule
